lisa_spi_target: RTL
====================

LISA_SPI_TARGET -- requirements
Module: lisa_spi_target

Interface
REQ-001 Parameter ADDR_BITS, default 24, address phase length in bits; legal values are 16 and 24.
REQ-002 Parameter DUMMY_CYCLES, default 4, SCLK cycles between the quad-read address and the data phase.
REQ-003 Port clk, input, 1, system clock; every flop is clocked on its rising edge.
REQ-004 Port rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-005 Port sclk, input, 1, SPI clock from the initiator, asynchronous to clk.
REQ-006 Port ce_n, input, 1, chip enable from the initiator, active-low, asynchronous to clk.
REQ-007 Port sio_i, input, 4, SIO3..SIO0 pad inputs; SIO0 is MOSI in single mode.
REQ-008 Port sio_o, output, 4, SIO3..SIO0 pad outputs; SIO1 is MISO in single mode.
REQ-009 Port sio_oe, output, 4, per-pin output enable, 1 = drive.
REQ-010 Port mem_valid/mem_we/mem_addr[23:0]/mem_wdata[7:0], outputs, byte-wide memory request.
REQ-011 Port mem_rdata[7:0]/mem_ready, inputs, memory response; a request completes on the clk where mem_valid && mem_ready.
REQ-012 Port busy, output, 1, high from synchronized CE fall to synchronized CE rise.
REQ-013 Port wel, output, 1, write-enable latch status.
REQ-014 Port underrun, output, 1, one-clk pulse when read data was not ready in time.

Function
REQ-015 sclk, ce_n and sio_i SHALL each pass through a 2-flop synchronizer; SPI edges are detected on the synchronized sclk; the design requires f(clk) >= 8x f(sclk).
REQ-016 SPI mode 0 SHALL apply: inputs sampled on the SCLK rising edge, outputs changed on the SCLK falling edge, MSB first, high nibble first in quad.
REQ-017 States SHALL be IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
REQ-018 On synchronized CE fall the FSM SHALL enter CMD and shift 8 single-bit command bits in on SIO0.
REQ-019 Command decode: 0x03 READ goes to ADDR (single); 0x02 WRITE goes to ADDR (single); 0xEB QREAD goes to ADDR (quad); 0x38 QWRITE goes to ADDR (quad).
REQ-020 Command 0x06 WREN SHALL set wel and go to IGNORE; every other opcode goes to IGNORE.
REQ-021 ADDR SHALL take ADDR_BITS bits, 1 per SCLK in single mode or 4 per SCLK in quad mode; for ADDR_BITS=16, mem_addr[23:16] is 0.
REQ-022 After ADDR, QREAD SHALL go to DUMMY for DUMMY_CYCLES SCLK rising edges with all sio_oe at 0; READ goes to RDATA; WRITE and QWRITE go to WDATA.
REQ-023 Reads SHALL prefetch: mem_valid with mem_we=0 is asserted on the clk after the final address (or final dummy) bit is sampled, and again as each byte's first bit is driven.
REQ-024 If read data is not held when the next byte's first falling edge arrives, 0xFF SHALL be shifted out and underrun pulses.
REQ-025 In RDATA, sio_oe SHALL be 4'b0010 (single) or 4'b1111 (quad); the first bit or nibble is driven on the first falling edge after state entry.
REQ-026 In WDATA, each completed byte SHALL issue one mem_valid/mem_we=1 request with mem_wdata equal to that byte; sio_oe is 0.
REQ-027 mem_addr SHALL increment by 1 after every completed byte and wrap modulo 2^ADDR_BITS.
REQ-028 mem_valid SHALL be held until mem_ready.
REQ-029 A new write byte that completes while the previous write is still pending SHALL be dropped and underrun pulses.
REQ-030 Synchronized CE rise from any state SHALL return the FSM to IDLE within 1 clk, drive sio_oe to 0, and discard any partial byte.
REQ-031 A pending mem request SHALL still complete after CE rise.
REQ-032 wel SHALL clear on the CE rise ending a WRITE or QWRITE that wrote at least one byte.
REQ-033 WRITE and QWRITE SHALL not depend on wel.

Reset
REQ-034 While rst is high, the FSM SHALL be in IDLE, and sio_o, sio_oe, mem_valid, mem_we, mem_addr, mem_wdata, busy, wel and underrun SHALL all be 0.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction; after rst falls, the next synchronized CE fall starts a fresh CMD phase.

Configuration
REQ-036 Macro LISA_SPI_TARGET_QUAD_EN: when defined, 0xEB and 0x38 SHALL be decoded as specified above.
REQ-037 When LISA_SPI_TARGET_QUAD_EN is undefined, 0xEB and 0x38 SHALL go to IGNORE, the DUMMY state and nibble shifting are omitted, and sio_oe[3:2] and sio_oe[0] are tied to 0.

Structure
REQ-038 A shared package SHALL hold the opcode constants (0x03, 0x02, 0xEB, 0x38, 0x06) and the state enumeration.
REQ-039 One sub-module, lisa_spi_sync, SHALL hold the 2-flop synchronizer plus SCLK rise/fall edge detect.

Verification
REQ-040 Test 1: CE low, 0x02, addr 0x000100, bytes 0xA5 0x5A -> writes 0xA5 to 0x000100 and 0x5A to 0x000101; wel unchanged.
REQ-041 Test 2: 0x03, addr 0xFFFFFF, memory {0xFFFFFF:0x12, 0x000000:0x34}, 16 SCLK -> MISO carries 0x12 then 0x34 (wrap).
REQ-042 Test 3 (QUAD_EN defined): 0xEB, addr 0x000010, 4 dummy cycles, 2 bytes from memory 0xC3,0x3C -> nibbles C,3,3,C on SIO3..0; sio_oe is 4'b1111 only during data.
REQ-043 Test 4: 0x06, then CE high, then 0x02 with 1 byte -> wel goes 1 then 0 at the second CE rise.
REQ-044 Test 5: 0x03 with mem_ready held low -> MISO carries 0xFF and underrun pulses once per byte.
REQ-045 Test 6: CE high after 5 bits of a write byte -> no mem request, FSM in IDLE, and the next command decodes correctly.

Source files
------------

// File: rtl/lisa_spi_target_pkg.sv
// Shared opcodes, FSM states and the synchronized-SPI bundle for lisa_spi_target.
package lisa_spi_target_pkg;

  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_QREAD  = 8'hEB;
  localparam logic [7:0] OP_QWRITE = 8'h38;
  localparam logic [7:0] OP_WREN   = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
  } state_t;

  typedef struct packed {
    logic       sclk_rise;
    logic       sclk_fall;
    logic       ce_fall;
    logic       ce_rise;
    logic [3:0] sio;
  } spi_sync_t;

endpackage

// File: rtl/lisa_spi_sync.sv
// 2-flop synchronizers for sclk/ce_n/sio plus edge detect on the synchronized copies.
module lisa_spi_sync
  import lisa_spi_target_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ce_n,
  input  logic [3:0] sio_i,
  output spi_sync_t  sync
);

  // [1] is the synchronized value, [2] its previous-clk copy for edge detect
  logic [2:0]      sclk_q;
  logic [2:0]      ce_q;
  logic [1:0][3:0] sio_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      ce_q   <= '1;
      sio_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      ce_q   <= {ce_q[1:0], ce_n};
      sio_q  <= {sio_q[0], sio_i};
    end
  end

  always_comb begin
    sync.sclk_rise = sclk_q[1] & ~sclk_q[2];
    sync.sclk_fall = ~sclk_q[1] & sclk_q[2];
    sync.ce_fall   = ~ce_q[1] & ce_q[2];
    sync.ce_rise   = ce_q[1] & ~ce_q[2];
    sync.sio       = sio_q[1];
  end

endmodule

// File: rtl/lisa_spi_target.sv
// SPI mode-0 memory target (single, optional quad) bridging to a byte-wide memory port.
// Quad opcodes 0xEB/0x38 exist only when LISA_SPI_TARGET_QUAD_EN is defined.
module lisa_spi_target
  import lisa_spi_target_pkg::*;
#(
  parameter int ADDR_BITS    = 24,
  parameter int DUMMY_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        ce_n,
  input  logic [3:0]  sio_i,
  output logic [3:0]  sio_o,
  output logic [3:0]  sio_oe,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        wel,
  output logic        underrun
);

  localparam logic [23:0] AMASK       = (ADDR_BITS == 16) ? 24'h00_FFFF : 24'hFF_FFFF;
  localparam logic [4:0]  ADDR_LAST_S = 5'(ADDR_BITS - 1);
  localparam logic [4:0]  ADDR_LAST_Q = 5'(ADDR_BITS / 4 - 1);
  localparam logic [4:0]  DUMMY_LAST  = 5'(DUMMY_CYCLES - 1);

  spi_sync_t   sy;
  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [23:0] shreg, shin;
  logic        quad, rd, wr, wrote, rd_hold;
  logic [7:0]  rd_buf, tx_sh, tx_byte;
  logic [2:0]  tx_cnt;
  logic        cmd_done, addr_done, dummy_done, wbyte_done;
  logic        is_rd_op, is_wr_op, is_q_op;

  lisa_spi_sync u_sync (.clk(clk), .rst(rst), .sclk(sclk), .ce_n(ce_n), .sio_i(sio_i), .sync(sy));

  always_comb begin
    // command phase is always single-bit; quad is the mode latched by the previous decode
    shin       = (quad && state != ST_CMD) ? {shreg[19:0], sy.sio} : {shreg[22:0], sy.sio[0]};
    cmd_done   = state == ST_CMD   && sy.sclk_rise && cnt == 5'd7;
    addr_done  = state == ST_ADDR  && sy.sclk_rise && cnt == (quad ? ADDR_LAST_Q : ADDR_LAST_S);
    dummy_done = state == ST_DUMMY && sy.sclk_rise && cnt == DUMMY_LAST;
    wbyte_done = state == ST_WDATA && sy.sclk_rise && cnt == (quad ? 5'd1 : 5'd7);
    is_q_op    = 1'b0;
`ifdef LISA_SPI_TARGET_QUAD_EN
    is_q_op    = shin[7:0] == OP_QREAD || shin[7:0] == OP_QWRITE;
`endif
    is_rd_op   = shin[7:0] == OP_READ  || (is_q_op && shin[7:0] == OP_QREAD);
    is_wr_op   = shin[7:0] == OP_WRITE || (is_q_op && shin[7:0] == OP_QWRITE);
    tx_byte    = rd_hold ? rd_buf : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (sy.ce_rise) state_nx = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:  if (sy.ce_fall) state_nx = ST_CMD;
        ST_CMD:   if (cmd_done)   state_nx = (is_rd_op || is_wr_op) ? ST_ADDR : ST_IGNORE;
        ST_ADDR:  if (addr_done)  state_nx = !rd ? ST_WDATA : (quad ? ST_DUMMY : ST_RDATA);
        ST_DUMMY: if (dummy_done) state_nx = ST_RDATA;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; shreg <= '0; quad <= 1'b0; rd <= 1'b0; wr <= 1'b0; wrote <= 1'b0;
      rd_hold <= 1'b0; rd_buf <= '0; tx_sh <= '0; tx_cnt <= '0;
      sio_o <= '0; sio_oe <= '0; mem_valid <= 1'b0; mem_we <= 1'b0;
      mem_addr <= '0; mem_wdata <= '0; busy <= 1'b0; wel <= 1'b0; underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (mem_valid && mem_ready) begin
        mem_valid <= 1'b0;
        mem_addr  <= (mem_addr + 24'd1) & AMASK;
        if (!mem_we) begin
          rd_buf  <= mem_rdata;
          rd_hold <= 1'b1;
        end
      end
      if (state_nx != state) cnt <= '0;
      else if (sy.sclk_rise && state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_WDATA})
        cnt <= wbyte_done ? 5'd0 : cnt + 5'd1;
      if (sy.sclk_rise && state inside {ST_CMD, ST_ADDR, ST_WDATA}) shreg <= shin;

      if (state == ST_IDLE && sy.ce_fall) begin
        busy <= 1'b1; wrote <= 1'b0; rd <= 1'b0; wr <= 1'b0;
      end
      if (sy.ce_rise) begin
        busy <= 1'b0;
        if (wr && wrote) wel <= 1'b0;
      end
      if (cmd_done) begin
        rd   <= is_rd_op;
        wr   <= is_wr_op;
        quad <= is_q_op;
        if (shin[7:0] == OP_WREN) wel <= 1'b1;
      end
      if (addr_done) begin
        mem_addr <= shin & AMASK;
        if (rd && !quad) begin mem_valid <= 1'b1; mem_we <= 1'b0; rd_hold <= 1'b0; end
      end
      if (dummy_done) begin mem_valid <= 1'b1; mem_we <= 1'b0; rd_hold <= 1'b0; end
      // one write in flight; a byte finishing behind it is lost
      if (wbyte_done) begin
        if (mem_valid) underrun <= 1'b1;
        else begin
          mem_valid <= 1'b1; mem_we <= 1'b1; mem_wdata <= shin[7:0]; wrote <= 1'b1;
        end
      end

      if (state_nx != ST_RDATA) begin
        sio_o <= '0; sio_oe <= '0; tx_cnt <= '0;
      end else if (state == ST_RDATA && sy.sclk_fall) begin
        sio_oe <= quad ? 4'hF : 4'h2;
        tx_cnt <= (tx_cnt == (quad ? 3'd1 : 3'd7)) ? 3'd0 : tx_cnt + 3'd1;
        if (tx_cnt == 3'd0) begin
          // byte boundary: consume prefetched byte and launch the next prefetch
          sio_o <= quad ? tx_byte[7:4] : {2'b00, tx_byte[7], 1'b0};
          tx_sh <= quad ? {tx_byte[3:0], 4'h0} : {tx_byte[6:0], 1'b0};
          if (rd_hold) rd_hold <= 1'b0;
          else         underrun <= 1'b1;
          if (!mem_valid) begin mem_valid <= 1'b1; mem_we <= 1'b0; end
        end else begin
          sio_o <= quad ? tx_sh[7:4] : {2'b00, tx_sh[7], 1'b0};
          tx_sh <= quad ? {tx_sh[3:0], 4'h0} : {tx_sh[6:0], 1'b0};
        end
      end
    end
  end

endmodule
